// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the jcscpu RAM arbiter: FSM states, requester
// IDs, bus widths and the latched-transaction record.
package ram_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_XFER,
        S_DONE
    } state_e;

    // Everything the sequencer needs once a grant is taken, frozen for the whole access
    typedef struct packed {
        logic              id;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } xact_t;

    function automatic xact_t select_xact(
        input logic              id,
        input logic              wr0,
        input logic              wr1,
        input logic [ADDR_W-1:0] addr0,
        input logic [ADDR_W-1:0] addr1,
        input logic [DATA_W-1:0] wdata0,
        input logic [DATA_W-1:0] wdata1
    );
        xact_t x;
        x.id    = id;
        x.wr    = (id == REQ_LDR) ? wr1    : wr0;
        x.addr  = (id == REQ_LDR) ? addr1  : addr0;
        x.wdata = (id == REQ_LDR) ? wdata1 : wdata0;
        return x;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side handshake plus RAM-side bus of the arbiter; the slave modport is
// the arbiter's view, the master modport is the surrounding system's view.
interface ram_arbiter_if;
    import ram_arb_pkg::*;

    logic              req0;
    logic              req1;
    logic              wr0;
    logic              wr1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              busy;

    logic [ADDR_W-1:0] bas;
    logic              wsa;
    logic [DATA_W-1:0] bis;
    logic              ws;
    logic              we;
    logic [DATA_W-1:0] bos;

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, bos,
        output ack0, ack1, rdata0, rdata1, busy, bas, wsa, bis, ws, we
    );

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, bos,
        input  ack0, ack1, rdata0, rdata1, busy, bas, wsa, bis, ws, we
    );

endinterface

// File: rtl/ram_arbiter_rr.sv
// Two-way grant logic: combinational winner selection plus a favoured-requester
// pointer that flips away from whoever was just served.
module rr_arbiter2
    import ram_arb_pkg::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic req0_i,
    input  logic req1_i,
    input  logic grant_commit_i,
    input  logic served_i,
    output logic gnt_o,
    output logic valid_o
);

    // ptr_q names the requester that wins the next tie
    logic ptr_q;

    always_comb begin
        valid_o = req0_i | req1_i;
        gnt_o   = REQ_CPU;
        if (req0_i && req1_i) begin
            gnt_o = RR_ENABLE ? ptr_q : REQ_CPU;
        end else if (req1_i) begin
            gnt_o = REQ_LDR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= REQ_CPU;
        end else if (grant_commit_i) begin
            ptr_q <= ~served_i;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single jcscpu RAM port between the CPU and the loader, sequencing
// each granted access as MAR load, data strobe, then a one-cycle acknowledge.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    ram_arbiter_if.slave arb_if
);

    state_e            state_q;
    state_e            state_d;
    xact_t             xact_q;
    xact_t             newXact;
    logic              grantId;
    logic              grantValid;
    logic              grantCommit;

    logic              wsa_q;
    logic              ws_q;
    logic              we_q;
    logic              ack0_q;
    logic              ack1_q;
    logic [ADDR_W-1:0] bas_q;
    logic [DATA_W-1:0] bis_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    assign grantCommit = (state_q == S_DONE);

    rr_arbiter2 #(
        .RR_ENABLE(RR_ENABLE)
    ) u_arb (
        .clk           (clk),
        .reset         (reset),
        .req0_i        (arb_if.req0),
        .req1_i        (arb_if.req1),
        .grant_commit_i(grantCommit),
        .served_i      (xact_q.id),
        .gnt_o         (grantId),
        .valid_o       (grantValid)
    );

    assign newXact = select_xact(grantId, arb_if.wr0, arb_if.wr1,
                                 arb_if.addr0, arb_if.addr1,
                                 arb_if.wdata0, arb_if.wdata1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = grantValid ? S_ADDR : S_IDLE;
            S_ADDR:  state_d = S_XFER;
            S_XFER:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered one state ahead so each lands exactly in its own state;
    // anything not set below defaults back to zero every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            xact_q   <= '0;
            wsa_q    <= 1'b0;
            ws_q     <= 1'b0;
            we_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            bas_q    <= '0;
            bis_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            wsa_q   <= 1'b0;
            ws_q    <= 1'b0;
            we_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            bas_q   <= '0;
            bis_q   <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (grantValid) begin
                        xact_q <= newXact;
                        wsa_q  <= 1'b1;
                        bas_q  <= newXact.addr;
                    end
                end
                S_ADDR: begin
                    if (xact_q.wr) begin
                        ws_q  <= 1'b1;
                        bis_q <= xact_q.wdata;
                    end else begin
                        we_q <= 1'b1;
                    end
                end
                S_XFER: begin
                    if (!xact_q.wr) begin
                        if (xact_q.id == REQ_LDR) begin
                            rdata1_q <= arb_if.bos;
                        end else begin
                            rdata0_q <= arb_if.bos;
                        end
                    end
                    if (xact_q.id == REQ_LDR) begin
                        ack1_q <= 1'b1;
                    end else begin
                        ack0_q <= 1'b1;
                    end
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign arb_if.wsa    = wsa_q;
    assign arb_if.ws     = ws_q;
    assign arb_if.we     = we_q;
    assign arb_if.bas    = bas_q;
    assign arb_if.bis    = bis_q;
    assign arb_if.ack0   = ack0_q;
    assign arb_if.ack1   = ack1_q;
    assign arb_if.rdata0 = rdata0_q;
    assign arb_if.rdata1 = rdata1_q;
    assign arb_if.busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: round-robin instance against a small RAM model,
// plus a fixed-priority instance for the tie-break behaviour.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic memLoad;
    logic monitorOn = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    ram_arbiter_if ifRr ();
    ram_arbiter_if ifFp ();

    ram_arbiter #(.RR_ENABLE(1'b1)) dutRr (.clk(clk), .reset(reset), .arb_if(ifRr));
    ram_arbiter #(.RR_ENABLE(1'b0)) dutFp (.clk(clk), .reset(reset), .arb_if(ifFp));

    always #5 clk = ~clk;

    // RAM model: MAR loads on wsa, write on ws, wired-OR read gated by we
    logic [7:0] mem [256];
    logic [7:0] mar;

    always @(posedge clk) begin
        if (memLoad) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h00] <= 8'h20;
            mem[8'h05] <= 8'h5A;
            mem[8'h06] <= 8'h66;
            mem[8'h20] <= 8'h11;
            mar        <= 8'h00;
        end else begin
            if (ifRr.wsa) mar <= ifRr.bas;
            if (ifRr.ws) mem[mar] <= ifRr.bis;
        end
    end

    assign ifRr.bos = ifRr.we ? mem[mar] : 8'h00;
    assign ifFp.bos = 8'h00;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit sel, input bit req, input bit wr,
                                 input logic [7:0] addr, input logic [7:0] wdata);
        if (sel) begin
            ifRr.req1 = req; ifRr.wr1 = wr; ifRr.addr1 = addr; ifRr.wdata1 = wdata;
        end else begin
            ifRr.req0 = req; ifRr.wr0 = wr; ifRr.addr0 = addr; ifRr.wdata0 = wdata;
        end
    endtask

    // One full access on the round-robin instance, checked cycle by cycle
    task automatic runAccess(input bit sel, input bit wr, input logic [7:0] addr,
                             input logic [7:0] wdata, input logic [7:0] expRd);
        applyStimulus(sel, 1'b1, wr, addr, wdata);
        nextCycle();
        checkOutput("wsaN1", ifRr.wsa, 1);
        checkOutput("basN1", ifRr.bas, addr);
        checkOutput("busyN1", ifRr.busy, 1);
        checkOutput("wsWeN1", {ifRr.ws, ifRr.we}, 0);
        nextCycle();
        checkOutput("wsN2", ifRr.ws, wr);
        checkOutput("weN2", ifRr.we, !wr);
        checkOutput("bisN2", ifRr.bis, wr ? wdata : 8'h00);
        checkOutput("basN2", ifRr.bas, 0);
        checkOutput("wsaN2", ifRr.wsa, 0);
        nextCycle();
        checkOutput("ackOwnN3", sel ? ifRr.ack1 : ifRr.ack0, 1);
        checkOutput("ackOtherN3", sel ? ifRr.ack0 : ifRr.ack1, 0);
        checkOutput("strobesN3", {ifRr.wsa, ifRr.ws, ifRr.we}, 0);
        if (!wr) checkOutput("rdataN3", sel ? ifRr.rdata1 : ifRr.rdata0, expRd);
        applyStimulus(sel, 1'b0, 1'b0, 8'h00, 8'h00);
        nextCycle();
        checkOutput("busyN4", ifRr.busy, 0);
        checkOutput("ackN4", {ifRr.ack0, ifRr.ack1}, 0);
    endtask

    always @(negedge clk) begin
        if (monitorOn) begin
            checkOutput("strobeExcl", ($countones({ifRr.wsa, ifRr.ws, ifRr.we}) > 1), 0);
            checkOutput("ackExclRr", ifRr.ack0 & ifRr.ack1, 0);
            checkOutput("ackExclFp", ifFp.ack0 & ifFp.ack1, 0);
        end
    end

    initial begin
        reset   = 1'b1;
        memLoad = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        ifFp.req0 = 1'b0; ifFp.wr0 = 1'b0; ifFp.addr0 = 8'h00; ifFp.wdata0 = 8'h00;
        ifFp.req1 = 1'b0; ifFp.wr1 = 1'b0; ifFp.addr1 = 8'h00; ifFp.wdata1 = 8'h00;
        nextCycle();
        nextCycle();
        memLoad = 1'b0;

        checkOutput("rstAck", {ifRr.ack0, ifRr.ack1}, 0);
        checkOutput("rstBusy", ifRr.busy, 0);
        checkOutput("rstStrobes", {ifRr.wsa, ifRr.ws, ifRr.we}, 0);
        checkOutput("rstBas", ifRr.bas, 0);
        checkOutput("rstBis", ifRr.bis, 0);
        checkOutput("rstRdata", {ifRr.rdata0, ifRr.rdata1}, 0);
        checkOutput("rstBusyFp", ifFp.busy, 0);
        monitorOn = 1'b1;
        reset = 1'b0;
        nextCycle();

        // Loader writes, then CPU reads it back
        runAccess(1'b1, 1'b1, 8'h10, 8'h2A, 8'h00);
        runAccess(1'b0, 1'b0, 8'h10, 8'h00, 8'h2A);

        // Address changes after grant must not leak into the in-flight read
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h05, 8'h00);
        nextCycle();
        ifRr.addr0 = 8'h06;
        checkOutput("basLatched", ifRr.bas, 8'h05);
        nextCycle();
        nextCycle();
        checkOutput("ackLatched", ifRr.ack0, 1);
        checkOutput("rdataLatched", ifRr.rdata0, 8'h5A);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        nextCycle();

        // Reset during the ADDR cycle of a write aborts it before ws
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h20, 8'hEE);
        nextCycle();
        checkOutput("abortWsa", ifRr.wsa, 1);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        nextCycle();
        checkOutput("abortWs", ifRr.ws, 0);
        checkOutput("abortWsa2", ifRr.wsa, 0);
        checkOutput("abortBusy", ifRr.busy, 0);
        checkOutput("abortAck", {ifRr.ack0, ifRr.ack1}, 0);
        checkOutput("abortBas", ifRr.bas, 0);
        checkOutput("abortRdata0", ifRr.rdata0, 0);
        reset = 1'b0;
        nextCycle();
        runAccess(1'b0, 1'b0, 8'h20, 8'h00, 8'h11);

        // rdata0 must survive a loader transaction
        runAccess(1'b0, 1'b0, 8'h00, 8'h00, 8'h20);
        runAccess(1'b1, 1'b0, 8'h10, 8'h00, 8'h2A);
        checkOutput("rdata0Held", ifRr.rdata0, 8'h20);

        // Both requesters held: alternation vs fixed priority
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
        ifFp.req0 = 1'b1;
        ifFp.req1 = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            nextCycle();
            checkOutput($sformatf("rrAck0_%0d", k), ifRr.ack0, (k == 3 || k == 11));
            checkOutput($sformatf("rrAck1_%0d", k), ifRr.ack1, (k == 7 || k == 15));
            checkOutput($sformatf("fpAck0_%0d", k), ifFp.ack0, (k % 4 == 3));
            checkOutput($sformatf("fpAck1_%0d", k), ifFp.ack1, 0);
            if (k == 15) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
                applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
                ifFp.req0 = 1'b0;
                ifFp.req1 = 1'b0;
            end
        end
        checkOutput("rrRdata1", ifRr.rdata1, 8'h2A);
        checkOutput("rrBusyEnd", ifRr.busy, 0);
        checkOutput("fpBusyEnd", ifFp.busy, 0);

        nextCycle();
        monitorOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Sequencer and two-way arbiter for the 256×8 `ram` block of the jcscpu. It shares the single RAM port between the CPU fetch/execute path (requester 0) and the program loader/debug port (requester 1). For each granted request it drives the RAM's two-step protocol: load the MAR via `bas`/`wsa`, then strobe `ws` for a write or `we` for a read. It then returns a one-cycle acknowledge, plus registered read data for reads.

## Interface
- `RR_ENABLE`, default 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 (CPU) always wins.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req0`, `req1` in 1: request; held high until that requester's `ack` pulse.
- `wr0`, `wr1` in 1: 1 = write, 0 = read; qualified by `req`.
- `addr0`, `addr1` in 8: RAM address.
- `wdata0`, `wdata1` in 8: write data.
- `ack0`, `ack1` out 1: one-cycle completion pulse.
- `rdata0`, `rdata1` out 8: read result, valid from the `ack` cycle and held until that requester's next read completes.
- `busy` out 1: high whenever the FSM is not IDLE.
- `bas` out 8: MAR input bus to the RAM.
- `wsa` out 1: MAR set strobe.
- `bis` out 8: RAM write data.
- `ws` out 1: RAM write strobe.
- `we` out 1: RAM read enable.
- `bos` in 8: RAM read data (wired-OR output; 0 when `we` is low).

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ADDR: `bas` = granted address, `wsa` = 1.
  - XFER: write drives `bis` = wdata, `ws` = 1; read drives `we` = 1 and registers `bos` into the granted requester's `rdata` at end of cycle.
  - DONE: pulse granted `ack`, update last-served pointer.
- Transitions:
  - IDLE→ADDR when any `req` is high.
  - ADDR→XFER and XFER→DONE unconditional.
  - DONE→IDLE unconditional; no back-to-back grant from DONE.
- Grant, address, wr flag and wdata are latched on the IDLE→ADDR edge. Later changes to requester inputs do not affect the in-flight transaction.
- Arbitration with RR_ENABLE=1:
  - Both requesting: grant the requester not served last.
  - After reset the pointer favours requester 0.
  - One requesting: grant it.
- Arbitration with RR_ENABLE=0: requester 0 always wins a tie.
- All RAM-side outputs are 0 in every cycle where they are not explicitly driven above. `bas` and `bis` are 0 outside ADDR and XFER respectively. In XFER, `bas` returns to 0; the MAR already holds the address.
- A requester that drops `req` before its `ack` still has its transaction completed and `ack` pulsed. The requester must not re-raise `req` for a new access until after `ack`.
- A requester whose `req` is still high in the cycle after its `ack` is treated as a new request.
- Reset mid-transaction: next state is IDLE. All strobes, `ack`s and `busy` go low immediately, and the pointer resets. A write aborted in ADDR never reaches RAM. `rdata0`/`rdata1` reset to 0.

## Timing
- Reset values: `ack0`/`ack1`/`busy`/`wsa`/`ws`/`we` = 0; `bas`/`bis`/`rdata0`/`rdata1` = 0; state IDLE; pointer = requester 0.
- `req` sampled high in IDLE at cycle N gives:
  - `busy` high at N+1 through N+3.
  - `wsa` at N+1.
  - `ws`/`we` at N+2.
  - `ack` at N+3; `rdata` valid at N+3.
- Latency from sampled request to `ack` is 3 cycles. Minimum spacing between grants is 4 cycles: IDLE at N+4, next ADDR at N+5.
- Only one of `wsa`, `ws`, `we` is high in any cycle; `ack0` and `ack1` are never high together.

## Structure
- Package `ram_arb_pkg` holds:
  - State enum: `S_IDLE`, `S_ADDR`, `S_XFER`, `S_DONE`.
  - Requester ID constants: `REQ_CPU` = 0, `REQ_LDR` = 1.
  - Width constants: `ADDR_W` = 8, `DATA_W` = 8.
- One sub-module, `rr_arbiter2`:
  - Combinational grant from `req0`/`req1`, the last-served pointer and RR_ENABLE.
  - Pointer register updated on a `grant_commit` pulse from DONE.
- Top-level `ram_arbiter` holds the FSM, latched request fields, RAM-side drive and `rdata` registers.

## Test plan
- After reset, `req1` writes 0x2A to addr 0x10 → `wsa` with `bas`=0x10 at N+1, `ws` with `bis`=0x2A at N+2, `ack1` at N+3. Then `req0` reads 0x10 → `rdata0` = 0x2A with `ack0` 3 cycles after grant.
- `req0` and `req1` both held continuously, RR_ENABLE=1 → grants alternate 0,1,0,1, one every 4 cycles. With RR_ENABLE=0 → requester 0 served every grant and `ack1` never pulses.
- `addr0` changed from 0x05 to 0x06 at cycle N+1 of a read of 0x05 → RAM sees `bas`=0x05, and `rdata0` = RAM[0x05].
- `reset` asserted during the ADDR cycle of a write to 0x20 (old value 0x11) → no `ws` pulse, all outputs 0 next cycle, later read of 0x20 returns 0x11.
- Read of addr 0x00 holding 0x20 → `we` high only at N+2, `rdata0` = 0x20 and held through an intervening requester-1 transaction. Every cycle: at most one of `wsa`/`ws`/`we` high, and `ack0`/`ack1` never high together.
